// File: rtl/usart_pkg.sv
// usart_pkg: shared constants for the USART transmit path.
//   CLK_FREQ / UART_BPS / BPS_CNT : system clock, line rate and cycles per bit.
//   ST_*                          : 2-bit state encoding of the transmit feeder FSM.
package usart_pkg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 115_200;
  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_STROBE    = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/usart_byte_fifo.sv
// usart_byte_fifo: single-clock byte FIFO with registered occupancy flags.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   wr_en, wr_data     : push request and byte (ignored while full)
//   rd_en, rd_data     : pop request; rd_data always shows the head entry
//   fifo_full/empty    : registered occupancy flags
//   fifo_count         : registered occupancy 0..DEPTH
//   overflow           : one-cycle pulse after a write was rejected while full
module usart_byte_fifo
  import usart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              push_s;
  logic              pop_s;

  // Full is the registered flag, so a same-cycle pop never frees room for a write.
  assign push_s  = wr_en && !full_r;
  assign pop_s   = rd_en && !empty_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Next occupancy; a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags and the overflow pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r    <= count_next_s;
      full_r     <= (count_next_s == CNT_MAX);
      empty_r    <= (count_next_s == '0);
      overflow_r <= wr_en && full_r;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge sys_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign fifo_full  = full_r;
  assign fifo_empty = empty_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: rtl/usart_tx_feeder.sv
// usart_tx_feeder: queues bytes and hands them one at a time to the USART
// transmitter with a clean usart_en rising edge per byte and an ack watchdog.
// Ports:
//   sys_clk, sys_rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data           : byte push into the queue
//   fifo_full/empty/count    : queue occupancy
//   overflow                 : pulse when a push was dropped (queue full)
//   ack_err                  : pulse when the transmitter never raised busy
//   usart_en, usart_din      : request strobe and data to the transmitter
//   usart_tx_busy            : transmitter frame-in-progress flag
//   tx_idle                  : FSM idle and queue empty
module usart_tx_feeder
  import usart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              ack_err,
  output logic              usart_en,
  output logic [7:0]        usart_din,
  input  logic              usart_tx_busy,
  output logic              tx_idle
);

  localparam logic [7:0]      TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic       pop_s;
  logic       push_s;
  logic       timeout_s;
  logic       cnt_zero_next_s;
  logic [7:0] tmo_cnt_r;
  logic       usart_en_r;
  logic [7:0] usart_din_r;
  logic       ack_err_r;
  logic       tx_idle_r;
  logic [7:0] fifo_rd_data_s;

  usart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (pop_s),
    .rd_data    (fifo_rd_data_s),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  assign push_s = wr_en && !fifo_full;

  // Next-state logic; the only pop happens on the IDLE->LOAD transition.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty && !usart_tx_busy) begin
          pop_s        = 1'b1;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: state_next_s = ST_STROBE;
      ST_STROBE: begin
        if (usart_tx_busy) begin
          state_next_s = ST_WAIT_DONE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STROBE;
        end
      end
      ST_WAIT_DONE: begin
        if (usart_tx_busy) begin
          state_next_s = ST_WAIT_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Predicts an empty queue after this edge so tx_idle can be registered.
  always_comb begin
    cnt_zero_next_s = fifo_empty;
    if (push_s) begin
      cnt_zero_next_s = 1'b0;
    end else if (pop_s) begin
      cnt_zero_next_s = (fifo_count == CNT_ONE);
    end else begin
      cnt_zero_next_s = fifo_empty;
    end
  end

  // FSM state, registered strobe/data/pulses and the ack watchdog counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      usart_en_r  <= 1'b0;
      usart_din_r <= 8'h00;
      tmo_cnt_r   <= 8'h00;
      ack_err_r   <= 1'b0;
      tx_idle_r   <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      // usart_en is high exactly while the FSM sits in STROBE.
      usart_en_r <= (state_next_s == ST_STROBE);
      if (pop_s) usart_din_r <= fifo_rd_data_s;
      // STROBE is only entered from LOAD, where the counter is already zero.
      if (state_r == ST_STROBE) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= 8'd0;
      end
      ack_err_r <= timeout_s;
      tx_idle_r <= (state_next_s == ST_IDLE) && cnt_zero_next_s;
    end
  end

  assign usart_en  = usart_en_r;
  assign usart_din = usart_din_r;
  assign ack_err   = ack_err_r;
  assign tx_idle   = tx_idle_r;

endmodule

// File: tb/tb_usart_tx_feeder.sv
// Scoreboard bench for usart_tx_feeder with a small transmitter model.
module tb_usart_tx_feeder;

  localparam int FRAME = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       ack_err;
  logic       usart_en;
  logic [7:0] usart_din;
  logic       usart_tx_busy;
  logic       tx_idle;

  logic       tx_model_on;
  logic       hold_busy;
  logic       model_busy;
  logic       en_q1;
  logic       en_q2;
  int         frame_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int   edges = 0;
  int   ack_cnt = 0;
  int   ovf_cnt = 0;
  int   hi_cnt = 0;
  int   last_width = 0;
  logic en_prev = 1'b0;
  logic [7:0] held_din;

  usart_tx_feeder dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .ack_err       (ack_err),
    .usart_en      (usart_en),
    .usart_din     (usart_din),
    .usart_tx_busy (usart_tx_busy),
    .tx_idle       (tx_idle)
  );

  always #10 sys_clk = ~sys_clk;

  assign usart_tx_busy = model_busy | hold_busy;

  // Transmitter model: 2-stage edge detect, busy for FRAME cycles.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q1 <= 1'b0; en_q2 <= 1'b0; model_busy <= 1'b0; frame_cnt <= 0;
    end else begin
      en_q1 <= usart_en;
      en_q2 <= en_q1;
      if (model_busy) begin
        if (frame_cnt == 0) model_busy <= 1'b0;
        else frame_cnt <= frame_cnt - 1;
      end else if (tx_model_on && en_q1 && !en_q2) begin
        model_busy <= 1'b1;
        frame_cnt  <= FRAME - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every usart_en rising edge is scored against the expected-byte queue.
  always @(negedge sys_clk) begin
    if (usart_en && !en_prev) begin
      edges++;
      hi_cnt = 1;
      held_din = usart_din;
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 32'(usart_din), 32'hFFFF_FFFF);
      end else begin
        chk("sb_din", 32'(usart_din), 32'(exp_q.pop_front()));
      end
    end else if (usart_en) begin
      hi_cnt++;
      chk("din_stable", 32'(usart_din), 32'(held_din));
    end else if (en_prev) begin
      last_width = hi_cnt;
    end
    if (ack_err)  ack_cnt++;
    if (overflow) ovf_cnt++;
    en_prev = usart_en;
  end

  task automatic push(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    @(posedge sys_clk); #1;
    wr_en = 1'b1; wr_data = b;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    @(posedge sys_clk); #1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(b);
      wr_en = 1'b1; wr_data = b;
      @(posedge sys_clk); #1;
      b = b + 8'd1;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!(tx_idle && !usart_tx_busy) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk(nm, 32'(n < 3000), 32'd1);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, a0, o0, n;
    sys_rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tx_model_on = 1'b1; hold_busy = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_en", 32'(usart_en), 32'd0);
    chk("rst_din", 32'(usart_din), 32'h00);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ackerr", 32'(ack_err), 32'd0);
    chk("rst_idle", 32'(tx_idle), 32'd1);
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    // 1: single byte
    e0 = edges;
    push(8'hA5, 1'b1);
    @(negedge sys_clk);
    chk("t1_count1", 32'(fifo_count), 32'd1);
    @(negedge sys_clk);
    chk("t1_load_din", 32'(usart_din), 32'hA5);
    chk("t1_load_en", 32'(usart_en), 32'd0);
    chk("t1_load_count", 32'(fifo_count), 32'd0);
    @(negedge sys_clk);
    chk("t1_strobe_en", 32'(usart_en), 32'd1);
    wait_idle("t1_idle");
    chk("t1_width", 32'(last_width), 32'd3);
    chk("t1_edges", 32'(edges - e0), 32'd1);

    // 2: burst to full plus an overflowing write
    e0 = edges; o0 = ovf_cnt;
    hold_busy = 1'b1;
    burst(8'h01, 16);
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_count16", 32'(fifo_count), 32'd16);
    push(8'hFF, 1'b0);
    chk("t2_ovf_pulse", 32'(overflow), 32'd1);
    hold_busy = 1'b0;
    wait_idle("t2_idle");
    chk("t2_edges", 32'(edges - e0), 32'd16);
    chk("t2_count0", 32'(fifo_count), 32'd0);
    chk("t2_ovf_cnt", 32'(ovf_cnt - o0), 32'd1);

    // 3: no transmitter -> ack timeout
    tx_model_on = 1'b0;
    e0 = edges; a0 = ack_cnt;
    push(8'h3C, 1'b1);
    wait_idle("t3_idle_a");
    chk("t3_width", 32'(last_width), 32'd8);
    chk("t3_ackerr", 32'(ack_cnt - a0), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd0);
    push(8'h3D, 1'b1);
    wait_idle("t3_idle_b");
    chk("t3_edges", 32'(edges - e0), 32'd2);
    chk("t3_ackerr2", 32'(ack_cnt - a0), 32'd2);
    tx_model_on = 1'b1;

    // 4: push while WAIT_DONE
    push(8'h11, 1'b1);
    n = 0;
    @(negedge sys_clk);
    while (!(usart_tx_busy && !usart_en) && n < 100) begin
      @(negedge sys_clk); n++;
    end
    chk("t4_reach_wait", 32'(n < 100), 32'd1);
    push(8'h55, 1'b1);
    chk("t4_count1", 32'(fifo_count), 32'd1);
    chk("t4_din_old", 32'(usart_din), 32'h11);
    n = 0;
    @(negedge sys_clk);
    while (usart_tx_busy && n < 100) begin
      @(negedge sys_clk); n++;
    end
    chk("t4_busy_fell", 32'(n < 100), 32'd1);
    @(negedge sys_clk);
    chk("t4_din_hold", 32'(usart_din), 32'h11);
    @(negedge sys_clk);
    chk("t4_din_new", 32'(usart_din), 32'h55);
    chk("t4_count0", 32'(fifo_count), 32'd0);
    wait_idle("t4_idle");

    // 5a: simultaneous push and pop at count 1
    hold_busy = 1'b1;
    push(8'h21, 1'b1);
    exp_q.push_back(8'h22);
    @(posedge sys_clk); #1;
    hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h22;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    chk("t5_count_same", 32'(fifo_count), 32'd1);
    chk("t5_din_first", 32'(usart_din), 32'h21);
    wait_idle("t5a_idle");

    // 5b: write at full with a same-cycle pop is rejected
    e0 = edges;
    hold_busy = 1'b1;
    burst(8'h30, 16);
    @(posedge sys_clk); #1;
    hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h99;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    chk("t5_full_ovf", 32'(overflow), 32'd1);
    chk("t5_count15", 32'(fifo_count), 32'd15);
    chk("t5_notfull", 32'(fifo_full), 32'd0);
    wait_idle("t5b_idle");
    chk("t5_edges", 32'(edges - e0), 32'd16);

    // 6: reset in the middle of STROBE
    tx_model_on = 1'b0;
    push(8'h77, 1'b1);
    push(8'h78, 1'b1);
    n = 0;
    @(negedge sys_clk);
    while (!usart_en && n < 50) begin
      @(negedge sys_clk); n++;
    end
    chk("t6_strobe_seen", 32'(n < 50), 32'd1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_en_async", 32'(usart_en), 32'd0);
    chk("t6_count_clr", 32'(fifo_count), 32'd0);
    chk("t6_idle", 32'(tx_idle), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    e0 = edges;
    repeat (30) @(negedge sys_clk);
    chk("t6_no_strobe", 32'(edges - e0), 32'd0);
    chk("t6_idle_after", 32'(tx_idle), 32'd1);
    chk("t6_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
